mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-ported data `memory` between the `seq_core` load/store path (port 0) and a second requester such as a program loader or debug port (port 1). It sits between the requesters and the memory's `read`/`write`/`address`/`data_input`/`data_output` pins. It serialises accesses with a req/ack handshake, waits out a fixed memory read latency, and returns read data to the winning port.

## Interface
- `A_SIZE`, 10, address width
- `D_SIZE`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles (≥1): data valid `MEM_LAT` cycles after the `read` cycle

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `m0_req`, `m1_req`  in  1  access request; held until ack
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; stable while req
- `m0_addr`, `m1_addr`  in  A_SIZE  word address; stable while req
- `m0_wdata`, `m1_wdata`  in  D_SIZE  write data; stable while req
- `m0_rdata`, `m1_rdata`  out  D_SIZE  read data; valid in ack cycle, held until next read ack on that port
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse
- `mem_read`, `mem_write`  out  1  memory strobes, one-hot or idle
- `mem_address`  out  A_SIZE  memory address
- `mem_data_out`  out  D_SIZE  data to memory `data_input`
- `mem_data_in`  in  D_SIZE  data from memory `data_output`

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any req, pick a winner, latch its we/addr/wdata and its index → ISSUE; else stay.
- ISSUE: drive `mem_read` (we=0) or `mem_write` (we=1) high for exactly this cycle, with the latched address and data. Load `cnt = MEM_LAT`. Write → IDLE with ack; read → WAIT.
- WAIT: decrement `cnt`. On the edge where `cnt` reaches 1→0, capture `mem_data_in` into the winner's rdata, pulse the winner's ack, → IDLE.
- Ack is registered and asserted for exactly one cycle, on the winning port only.
- A requester whose req is still high in the cycle after its ack is a new request.
- `mem_address` and `mem_data_out` hold their last latched values outside ISSUE. Strobes are 0 outside ISSUE.
- Only one access is outstanding at a time; no pipelining.
- Requests are never dropped: a losing req stays pending and is served later.

## Timing
- Reset values:
  - state IDLE
  - all strobes, acks 0
  - `mem_address`, `mem_data_out`, `m*_rdata` 0
  - `cnt` 0
  - round-robin pointer → port 0
- Write: req sampled at edge N; `mem_write` high in cycle N+1; ack high in cycle N+2.
- Read: req sampled at edge N; `mem_read` high in cycle N+1; ack and rdata valid in cycle N+2+MEM_LAT.
- Back-to-back: IDLE is revisited for one cycle after every ack. Minimum spacing between strobes is 3 cycles (write) or MEM_LAT+3 cycles (read).
- Simultaneous req from both ports in IDLE: resolved per Configuration.
- A req arriving during ISSUE/WAIT is held pending and evaluated in the next IDLE.
- Reset asserted mid-access:
  - immediate return to IDLE, strobes and acks cleared
  - no ack is ever issued for the aborted access
  - memory contents may already reflect an ISSUE-cycle write

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. The pointer names the preferred port; after each grant it moves to the other port. Under continuous contention grants alternate 0,1,0,1…
- Not defined: fixed priority, port 0 (core) always wins on a tie. The pointer logic is omitted.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ISSUE, WAIT}
  - port index localparams `PORT_CORE=0`, `PORT_AUX=1`
- Sub-module `arb_pick`: combinational two-way picker. Inputs are the req pair and the pointer; outputs are the grant index and a valid flag. It contains the `MEM_ARB_RR_EN` variant selection.
- The FSM, latency counter and output registers live in `mem_arbiter`.

## Test plan
- Single write then read, port 0:
  - write addr 0x005 data 0xDEADBEEF → `mem_write` in cycle N+1, ack in N+2
  - read addr 0x005 → ack in N+3 (MEM_LAT=1) with `m0_rdata` = 0xDEADBEEF
- Simultaneous reads from both ports to 0x010 (0x11111111) and 0x020 (0x22222222):
  - RR: port 0 acks first, then port 1, each with the correct data
  - fixed priority: same order
- Continuous contention, 8 accesses, both reqs held high:
  - with `MEM_ARB_RR_EN`: grants alternate 0,1,0,1…
  - without: port 1 is served only after port 0 drops req
- MEM_LAT=3 read:
  - ack exactly 5 cycles after the sampling edge
  - `mem_read` high for exactly 1 cycle
  - no other strobe during WAIT
- Reset asserted during WAIT of a port 1 read:
  - strobes and acks 0 immediately
  - no ack after release
  - the next port 1 request completes normally
- Port 1 holds req across its ack:
  - treated as a second access with a second strobe and a second ack
  - a pending port 0 request is granted first under RR

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   arb_state_t : arbiter FSM states
//   PORT_CORE   : index of the seq_core load/store port (port 0)
//   PORT_AUX    : index of the loader/debug port (port 1)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational two-way request picker.
//   req   in  [1:0]  request pair, bit index = port index
//   ptr   in  1      preferred port on a tie (round-robin build only)
//   grant out 1      index of the winning port
//   valid out 1      at least one request present
// Build option: MEM_ARB_RR_EN selects round-robin; otherwise port 0 wins ties.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant,
  output logic       valid
);

  assign valid = |req;

`ifdef MEM_ARB_RR_EN
  // On a tie the pointer decides; otherwise the lone requester wins.
  assign grant = (&req) ? ptr : req[PORT_AUX];
`else
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign grant = req[PORT_CORE] ? PORT_CORE : PORT_AUX;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported data memory between the core
// load/store path (port 0) and an auxiliary requester (port 1).
//   clk, rst                  clock, asynchronous active-high reset
//   m{0,1}_req/we/addr/wdata  request handshake inputs, held until ack
//   m{0,1}_rdata              read data, held until the next read ack
//   m{0,1}_ack                one-cycle completion pulse
//   mem_read/mem_write        memory strobes, high only in ISSUE
//   mem_address/mem_data_out  latched address / write data to memory
//   mem_data_in               memory read data, valid MEM_LAT cycles after read
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; the default
// build uses fixed priority with port 0 winning ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned A_SIZE  = 10,
  parameter int unsigned D_SIZE  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [A_SIZE-1:0] m0_addr,
  input  logic [D_SIZE-1:0] m0_wdata,
  output logic [D_SIZE-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [A_SIZE-1:0] m1_addr,
  input  logic [D_SIZE-1:0] m1_wdata,
  output logic [D_SIZE-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              mem_read,
  output logic              mem_write,
  output logic [A_SIZE-1:0] mem_address,
  output logic [D_SIZE-1:0] mem_data_out,
  input  logic [D_SIZE-1:0] mem_data_in
);

  localparam int unsigned CntW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  arb_state_t        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sel_q, we_q;
  logic [A_SIZE-1:0] addr_q;
  logic [D_SIZE-1:0] wdata_q, rdata0_q, rdata1_q;
  logic [1:0]        ack_q, ack_d;
  logic              grant, valid, ptr, start, rd_done, wr_done;

  arb_pick u_pick (
    .req   ({m1_req, m0_req}),
    .ptr   (ptr),
    .grant (grant),
    .valid (valid)
  );

`ifdef MEM_ARB_RR_EN
  logic ptr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PORT_CORE;
    end else if (start) begin
      ptr_q <= ~grant;
    end
  end
  assign ptr = ptr_q;
`else
  assign ptr = PORT_CORE;
`endif

  // The IDLE cycle that carries an ack does not arbitrate: the acked port is
  // still holding req, and this keeps the minimum strobe spacing.
  assign start = (state_q == IDLE) && valid && !(|ack_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: begin
        cnt_d   = CntW'(MEM_LAT);
        state_d = we_q ? IDLE : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = (state_q == ISSUE) && !we_q;
    mem_write = (state_q == ISSUE) && we_q;
    wr_done   = (state_q == ISSUE) && we_q;
    rd_done   = (state_q == WAIT) && (cnt_q == CntW'(1));
    ack_d     = '0;
    if (wr_done || rd_done) ack_d[sel_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= PORT_CORE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack_q    <= '0;
    end else begin
      ack_q <= ack_d;
      if (start) begin
        sel_q   <= grant;
        we_q    <= grant ? m1_we : m0_we;
        addr_q  <= grant ? m1_addr : m0_addr;
        wdata_q <= grant ? m1_wdata : m0_wdata;
      end
      if (rd_done) begin
        if (sel_q == PORT_AUX) rdata1_q <= mem_data_in;
        else                   rdata0_q <= mem_data_in;
      end
    end
  end

  assign mem_address  = addr_q;
  assign mem_data_out = wdata_q;
  assign m0_rdata     = rdata0_q;
  assign m1_rdata     = rdata1_q;
  assign m0_ack       = ack_q[PORT_CORE];
  assign m1_ack       = ack_q[PORT_AUX];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Instance 0 uses MEM_LAT=1,
// instance 1 uses MEM_LAT=3; each has its own behavioural memory.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2][2];
  logic        we    [2][2];
  logic [9:0]  addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [31:0] rdata [2][2];
  logic        ack   [2][2];
  logic        mem_read [2], mem_write [2];
  logic [9:0]  mem_address [2];
  logic [31:0] mem_data_out [2], mem_data_in [2];

  logic [31:0] mem  [2][1024];
  logic [31:0] pipe [2][3];
  logic [31:0] held [2][2];
  int          strobes [2];
  int          both_hot;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.A_SIZE(10), .D_SIZE(32), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
    .m0_rdata(rdata[0][0]), .m0_ack(ack[0][0]),
    .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
    .m1_rdata(rdata[0][1]), .m1_ack(ack[0][1]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_address(mem_address[0]),
    .mem_data_out(mem_data_out[0]), .mem_data_in(mem_data_in[0])
  );

  mem_arbiter #(.A_SIZE(10), .D_SIZE(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
    .m0_rdata(rdata[1][0]), .m0_ack(ack[1][0]),
    .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
    .m1_rdata(rdata[1][1]), .m1_ack(ack[1][1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_address(mem_address[1]),
    .mem_data_out(mem_data_out[1]), .mem_data_in(mem_data_in[1])
  );

  // Memory models: read data appears 1 (instance 0) or 3 (instance 1) cycles
  // after the read cycle; a poison value shows up outside that window.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_write[d]) mem[d][mem_address[d]] <= mem_data_out[d];
      pipe[d][0] <= mem_read[d] ? mem[d][mem_address[d]] : 32'hBAD0BAD0;
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
      if (mem_read[d] || mem_write[d]) strobes[d] <= strobes[d] + 1;
      if (mem_read[d] && mem_write[d]) both_hot <= both_hot + 1;
    end
  end
  assign mem_data_in[0] = pipe[0][0];
  assign mem_data_in[1] = pipe[1][2];

  typedef struct {
    int          d;
    int          p;
    bit          w;
    logic [9:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      held[d][0] = '0;
      held[d][1] = '0;
    end
  endtask

  // One access on one port; latency counted from the edge that samples req.
  task automatic acc(input int d, input int p, input bit w, input logic [9:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int lat);
    int cyc;
    int s0;
    bit seen;
    bit s_ok;
    bit other;
    @(posedge clk);
    #1;
    req[d][p] = 1'b1;
    we[d][p] = w;
    addr[d][p] = a;
    wdata[d][p] = wd;
    s0 = strobes[d];
    seen = 1'b0;
    s_ok = 1'b0;
    other = 1'b0;
    cyc = 0;
    @(posedge clk);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1)
        s_ok = (w ? (mem_write[d] && !mem_read[d]) : (mem_read[d] && !mem_write[d])) &&
               (mem_address[d] == a) && (!w || mem_data_out[d] == wd);
      if (ack[d][p]) begin
        seen = 1'b1;
        other = ack[d][1-p];
      end
    end
    req[d][p] = 1'b0;
    if (!w) held[d][p] = rd;
    chk("ack_latency", 64'(seen ? cyc : 999), 64'(lat));
    chk("strobe_cycle", 64'(s_ok), 64'd1);
    chk("other_port_ack", 64'(other), 64'd0);
    chk("rdata", 64'(rdata[d][p]), 64'(held[d][p]));
    chk("strobe_count", 64'(strobes[d] - s0), 64'd1);
  endtask

  initial begin
    int t0, t1, cyc, s0;
    int order[$];
    int times[$];

    vecs[0] = '{0, 0, 1'b1, 10'h005, 32'hDEADBEEF, 32'h0, 2};
    vecs[1] = '{0, 0, 1'b0, 10'h005, 32'h0, 32'hDEADBEEF, 3};
    vecs[2] = '{0, 0, 1'b1, 10'h010, 32'h11111111, 32'h0, 2};
    vecs[3] = '{0, 1, 1'b1, 10'h020, 32'h22222222, 32'h0, 2};
    vecs[4] = '{0, 1, 1'b0, 10'h005, 32'h0, 32'hDEADBEEF, 3};
    vecs[5] = '{0, 1, 1'b1, 10'h3FF, 32'hA5A5A5A5, 32'h0, 2};
    vecs[6] = '{0, 0, 1'b0, 10'h3FF, 32'h0, 32'hA5A5A5A5, 3};
    vecs[7] = '{1, 0, 1'b1, 10'h0AA, 32'hCAFEF00D, 32'h0, 2};
    vecs[8] = '{1, 0, 1'b0, 10'h0AA, 32'h0, 32'hCAFEF00D, 5};
    vecs[9] = '{1, 1, 1'b0, 10'h0AA, 32'h0, 32'hCAFEF00D, 5};

    both_hot = 0;
    for (int d = 0; d < 2; d++) begin
      strobes[d] = 0;
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0;
        we[d][p] = 1'b0;
        addr[d][p] = '0;
        wdata[d][p] = '0;
        held[d][p] = '0;
      end
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk("reset_strobes", 64'({mem_read[d], mem_write[d]}), 64'd0);
      chk("reset_acks", 64'({ack[d][0], ack[d][1]}), 64'd0);
      chk("reset_address", 64'(mem_address[d]), 64'd0);
      chk("reset_data_out", 64'(mem_data_out[d]), 64'd0);
      chk("reset_rdata0", 64'(rdata[d][0]), 64'd0);
      chk("reset_rdata1", 64'(rdata[d][1]), 64'd0);
    end
    rst = 1'b0;

    foreach (vecs[i])
      acc(vecs[i].d, vecs[i].p, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].lat);

    // Simultaneous reads from a fresh pointer: port 0 first in both builds.
    do_reset();
    @(posedge clk);
    #1;
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 10'h010;
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 10'h020;
    @(posedge clk);
    t0 = 999; t1 = 999; cyc = 0;
    for (int i = 0; i < 30 && (t0 == 999 || t1 == 999); i++) begin
      @(negedge clk);
      cyc++;
      if (ack[0][0]) begin t0 = cyc; req[0][0] = 1'b0; end
      if (ack[0][1]) begin t1 = cyc; req[0][1] = 1'b0; end
    end
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    chk("simul_p0_ack_cycle", 64'(t0), 64'd3);
    chk("simul_p1_ack_cycle", 64'(t1), 64'd7);
    chk("simul_p0_rdata", 64'(rdata[0][0]), 64'h11111111);
    chk("simul_p1_rdata", 64'(rdata[0][1]), 64'h22222222);

    // Continuous contention with writes on both ports.
    @(posedge clk);
    #1;
    req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 10'h040; wdata[0][0] = 32'h40;
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 10'h041; wdata[0][1] = 32'h41;
    order.delete();
    for (int i = 0; i < 200 && order.size() < 9; i++) begin
      @(negedge clk);
      if (ack[0][0]) order.push_back(0);
      if (ack[0][1]) order.push_back(1);
      if (order.size() >= 8) req[0][0] = 1'b0;
    end
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    for (int i = 0; i < 8; i++)
      chk("contention_grant", 64'(i < order.size() ? order[i] : 9), 64'(Rr ? i % 2 : 0));
    chk("contention_after_drop", 64'(order.size() > 8 ? order[8] : 9), 64'd1);

    // Port 1 holds req across its ack while port 0 becomes pending.
    @(posedge clk);
    #1;
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 10'h050; wdata[0][1] = 32'h50;
    we[0][0] = 1'b1; addr[0][0] = 10'h051; wdata[0][0] = 32'h51;
    s0 = strobes[0];
    @(posedge clk);
    order.delete();
    times.delete();
    cyc = 0;
    for (int i = 0; i < 40 && order.size() < 3; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req[0][0] = 1'b1;
      if (ack[0][0]) begin order.push_back(0); times.push_back(cyc); req[0][0] = 1'b0; end
      if (ack[0][1]) begin
        order.push_back(1);
        times.push_back(cyc);
        if (order.size() >= 3) req[0][1] = 1'b0;
      end
    end
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_grant_order", 64'(i < order.size() ? order[i] : 9), 64'(i == 1 ? 0 : 1));
      chk("hold_ack_cycle", 64'(i < times.size() ? times[i] : 999), 64'(2 + 3 * i));
    end
    @(posedge clk);
    chk("hold_strobe_count", 64'(strobes[0] - s0), 64'd3);

    // Reset during WAIT of a port 1 read on the MEM_LAT=3 instance.
    @(posedge clk);
    #1;
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 10'h0AA;
    @(posedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_strobes", 64'({mem_read[1], mem_write[1]}), 64'd0);
    chk("abort_acks", 64'({ack[1][0], ack[1][1]}), 64'd0);
    req[1][1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    held[1][0] = '0;
    held[1][1] = '0;
    t0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack[1][0] || ack[1][1]) t0++;
    end
    chk("abort_no_ack", 64'(t0), 64'd0);
    acc(1, 1, 1'b0, 10'h0AA, 32'h0, 32'hCAFEF00D, 5);

    chk("strobes_one_hot", 64'(both_hot), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
